// File: rtl/motor_cmd_sequencer_pkg.sv
// Shared state encoding and H-bridge direction codes for the motor command sequencer.
package motor_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    DEAD = 2'd1,
    RAMP = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [3:0] CODE_FWD   = 4'b1001;
  localparam logic [3:0] CODE_LEFT  = 4'b1010;
  localparam logic [3:0] CODE_RIGHT = 4'b0101;
  localparam logic [3:0] CODE_STOP  = 4'b0000;

  function automatic logic is_motion(input logic [3:0] code);
    return (code == CODE_FWD) || (code == CODE_LEFT) || (code == CODE_RIGHT);
  endfunction

endpackage

// File: rtl/motor_cmd_sequencer_pwm_gen.sv
// Free-running 8-bit PWM counter with comparator; pwm is high while the count is below duty.
module pwm_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty,
  output logic       pwm
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'd0;
    else     cnt <= cnt + 8'd1;
  end

  assign pwm = (cnt < duty);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// H-bridge command sequencer: dead time before every new direction, linear duty ramp, registered outputs.
module motor_cmd_sequencer
  import motor_cmd_sequencer_pkg::*;
#(
  parameter int DEAD_CYC      = 100000,
  parameter int RAMP_STEP_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_ON,
  input  logic [3:0] IN_req,
  input  logic [7:0] duty,
  output logic [3:0] IN,
  output logic [1:0] EN,
  output logic       busy
);

  localparam int DCW = (DEAD_CYC > 2) ? $clog2(DEAD_CYC) : 1;
  localparam int RCW = (RAMP_STEP_CYC > 2) ? $clog2(RAMP_STEP_CYC) : 1;
  localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_CYC - 1);
  localparam logic [RCW-1:0] RAMP_LOAD = RCW'(RAMP_STEP_CYC - 1);

  state_t           state, nxt;
  logic [3:0]       req_q, target, nxt_target, nxt_in;
  logic             on_q, pwm, drive;
  logic [DCW-1:0]   dead_cnt, nxt_dead;
  logic [RCW-1:0]   ramp_cnt, nxt_ramp;
  logic [7:0]       app_duty, nxt_app;

  pwm_gen u_pwm (
    .clk  (clk),
    .rst  (rst),
    .duty (app_duty),
    .pwm  (pwm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= CODE_STOP;
      on_q     <= 1'b0;
      state    <= STOP;
      target   <= CODE_STOP;
      dead_cnt <= '0;
      ramp_cnt <= '0;
      app_duty <= 8'd0;
      IN       <= CODE_STOP;
      EN       <= 2'b00;
      busy     <= 1'b0;
    end else begin
      req_q    <= IN_req;
      on_q     <= sw_ON;
      state    <= nxt;
      target   <= nxt_target;
      dead_cnt <= nxt_dead;
      ramp_cnt <= nxt_ramp;
      app_duty <= nxt_app;
      IN       <= nxt_in;
      EN       <= drive ? {2{pwm}} : 2'b00;
      busy     <= (nxt == DEAD) || (nxt == RAMP);
    end
  end

  always_comb begin
    nxt        = state;
    nxt_target = target;
    nxt_dead   = dead_cnt;
    nxt_ramp   = ramp_cnt;
    nxt_app    = app_duty;
    nxt_in     = IN;
    // Switch-off or a stop-class request outranks every other transition.
    if (!on_q || !is_motion(req_q)) begin
      nxt        = STOP;
      nxt_target = CODE_STOP;
      nxt_dead   = '0;
      nxt_ramp   = '0;
      nxt_app    = 8'd0;
      nxt_in     = CODE_STOP;
    end else begin
      case (state)
        STOP: begin
          nxt        = DEAD;
          nxt_target = req_q;
          nxt_dead   = DEAD_LOAD;
          nxt_app    = 8'd0;
        end
        DEAD: begin
          if (req_q != target) begin
            nxt_target = req_q;
            nxt_dead   = DEAD_LOAD;
          end else if (dead_cnt == '0) begin
            nxt      = RAMP;
            nxt_in   = target;
            nxt_app  = 8'd0;
            nxt_ramp = RAMP_LOAD;
          end else begin
            nxt_dead = dead_cnt - 1'b1;
          end
        end
        RAMP, RUN: begin
          // Any direction change drops the bridge to 0000 on this same edge.
          if (req_q != IN) begin
            nxt        = DEAD;
            nxt_target = req_q;
            nxt_dead   = DEAD_LOAD;
            nxt_app    = 8'd0;
            nxt_in     = CODE_STOP;
          end else if (state == RAMP) begin
            if (app_duty >= duty) begin
              nxt     = RUN;
              nxt_app = duty;
            end else if (ramp_cnt == '0) begin
              nxt_app  = app_duty + 8'd1;
              nxt_ramp = RAMP_LOAD;
            end else begin
              nxt_ramp = ramp_cnt - 1'b1;
            end
          end else if (duty > app_duty) begin
            nxt      = RAMP;
            nxt_ramp = RAMP_LOAD;
          end else begin
            nxt_app = duty;
          end
        end
        default: nxt = STOP;
      endcase
    end
  end

  assign drive = (nxt == RAMP) || (nxt == RUN);

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed self-checking bench for motor_cmd_sequencer with DEAD_CYC=4, RAMP_STEP_CYC=2.
module tb_motor_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_ON;
  logic [3:0] IN_req;
  logic [7:0] duty;
  logic [3:0] IN;
  logic [1:0] EN;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_cmd_sequencer #(
    .DEAD_CYC      (4),
    .RAMP_STEP_CYC (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_ON  (sw_ON),
    .IN_req (IN_req),
    .duty   (duty),
    .IN     (IN),
    .EN     (EN),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Samples EN over n cycles; reports cycles with EN=11 and cycles where the two bits differ.
  task automatic count_en(input int n, output int hi, output int uneq);
    hi   = 0;
    uneq = 0;
    repeat (n) begin
      tick(1);
      if (EN == 2'b11) hi++;
      if (EN[1] != EN[0]) uneq++;
    end
  endtask

  int hi, uneq;

  initial begin
    rst    = 1'b1;
    sw_ON  = 1'b0;
    IN_req = 4'b0000;
    duty   = 8'd0;
    tick(3);
    check("rst_IN", 32'(IN), 32'h0);
    check("rst_EN", 32'(EN), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(2);
    check("idle_IN", 32'(IN), 32'h0);

    // Forward start: 2-cycle latency, 4 dead cycles, ramp 1,2,3 every 2 cycles.
    sw_ON  = 1'b1;
    IN_req = 4'b1001;
    duty   = 8'd3;
    tick(1);
    check("fwd_e1_IN", 32'(IN), 32'h0);
    check("fwd_e1_busy", 32'(busy), 32'h0);
    for (int e = 2; e <= 5; e++) begin
      tick(1);
      check($sformatf("fwd_dead_e%0d_IN", e), 32'(IN), 32'h0);
      check($sformatf("fwd_dead_e%0d_busy", e), 32'(busy), 32'h1);
    end
    tick(1);
    check("fwd_e6_IN", 32'(IN), 32'h9);
    check("fwd_e6_app", 32'(dut.app_duty), 32'h0);
    tick(1);
    check("fwd_e7_app", 32'(dut.app_duty), 32'h0);
    tick(1);
    check("fwd_e8_app", 32'(dut.app_duty), 32'h1);
    tick(2);
    check("fwd_e10_app", 32'(dut.app_duty), 32'h2);
    tick(2);
    check("fwd_e12_app", 32'(dut.app_duty), 32'h3);
    check("fwd_e12_busy", 32'(busy), 32'h1);
    tick(1);
    check("fwd_e13_busy", 32'(busy), 32'h0);
    count_en(256, hi, uneq);
    check("fwd_run_en_hi", 32'(hi), 32'd3);
    check("fwd_run_en_eq", 32'(uneq), 32'd0);

    // Direction change in RUN: 0000 on the next registered edge, full dead, fresh ramp.
    IN_req = 4'b1010;
    tick(1);
    check("left_e1_IN", 32'(IN), 32'h9);
    for (int e = 2; e <= 5; e++) begin
      tick(1);
      check($sformatf("left_dead_e%0d_IN", e), 32'(IN), 32'h0);
      check($sformatf("left_dead_e%0d_EN", e), 32'(EN), 32'h0);
    end
    tick(1);
    check("left_e6_IN", 32'(IN), 32'ha);
    check("left_e6_app", 32'(dut.app_duty), 32'h0);
    tick(8);
    check("left_run_busy", 32'(busy), 32'h0);

    // Retarget during DEAD restarts the dead counter; 1001 must never appear.
    IN_req = 4'b1001;
    tick(1);
    check("re_e1_IN", 32'(IN), 32'ha);
    tick(1);
    check("re_e2_IN", 32'(IN), 32'h0);
    tick(1);
    check("re_e3_IN", 32'(IN), 32'h0);
    IN_req = 4'b0101;
    for (int e = 4; e <= 8; e++) begin
      tick(1);
      check($sformatf("re_dead_e%0d_IN", e), 32'(IN), 32'h0);
    end
    tick(1);
    check("re_e9_IN", 32'(IN), 32'h5);
    tick(8);
    check("re_run_busy", 32'(busy), 32'h0);

    // Switch-off and invalid code both force STOP within 2 cycles.
    sw_ON = 1'b0;
    tick(1);
    check("off_e1_IN", 32'(IN), 32'h5);
    tick(1);
    check("off_e2_IN", 32'(IN), 32'h0);
    check("off_e2_EN", 32'(EN), 32'h0);
    check("off_e2_busy", 32'(busy), 32'h0);
    sw_ON = 1'b1;
    tick(16);
    check("on_run_IN", 32'(IN), 32'h5);
    check("on_run_busy", 32'(busy), 32'h0);
    IN_req = 4'b1111;
    tick(2);
    check("inv_IN", 32'(IN), 32'h0);
    check("inv_EN", 32'(EN), 32'h0);
    check("inv_busy", 32'(busy), 32'h0);

    // duty=0 holds the direction with the bridge disabled.
    duty   = 8'd0;
    IN_req = 4'b1001;
    tick(8);
    check("d0_IN", 32'(IN), 32'h9);
    check("d0_busy", 32'(busy), 32'h0);
    count_en(520, hi, uneq);
    check("d0_en_hi", 32'(hi), 32'd0);
    check("d0_IN_after", 32'(IN), 32'h9);

    // duty=255: ramp back up, then EN low exactly once per 256 cycles.
    duty = 8'd255;
    tick(1);
    check("d255_ramp_busy", 32'(busy), 32'h1);
    tick(520);
    check("d255_busy", 32'(busy), 32'h0);
    check("d255_app", 32'(dut.app_duty), 32'hff);
    count_en(512, hi, uneq);
    check("d255_en_lo", 32'(512 - hi), 32'd2);
    check("d255_en_eq", 32'(uneq), 32'd0);

    // Asynchronous reset mid-RAMP, then a full dead period again.
    IN_req = 4'b1010;
    tick(8);
    check("rr_pre_IN", 32'(IN), 32'ha);
    check("rr_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("rr_async_IN", 32'(IN), 32'h0);
    check("rr_async_EN", 32'(EN), 32'h0);
    check("rr_async_busy", 32'(busy), 32'h0);
    tick(2);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      check($sformatf("rr_dead_e%0d_IN", e), 32'(IN), 32'h0);
    end
    tick(1);
    check("rr_e6_IN", 32'(IN), 32'ha);

    // Reset mid-DEAD leaves no target behind.
    IN_req = 4'b1001;
    tick(4);
    check("rd_dead_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("rd_async_busy", 32'(busy), 32'h0);
    tick(1);
    IN_req = 4'b0000;
    rst    = 1'b0;
    tick(10);
    check("rd_after_IN", 32'(IN), 32'h0);
    check("rd_after_busy", 32'(busy), 32'h0);
    IN_req = 4'b0101;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      check($sformatf("rd_dead_e%0d_IN", e), 32'(IN), 32'h0);
    end
    tick(1);
    check("rd_e6_IN", 32'(IN), 32'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
